user_dr_bank: RTL and testbench
===============================

// Module: user_dr_bank
// PURPOSE
//  Multi-channel JTAG user data register with capture, shift and update stages.
//  A selected channel's parallel status is captured into one shared shift chain and shifted
//  out LSB first, while new data is shifted in from TDI.
//  On UPDATE the shifted word is committed to that channel's shadow output, but only if the
//  shift length was exactly WIDTH.
//  Sits behind the BSCAN user-instruction decode; drives per-channel control words to FEB logic.
// PARAMETERS
//  WIDTH   16  bits per channel word (>=2)
//  NCH     4   number of channels (>=1)
//  CHW     2   channel index width, = clog2(NCH) (1 when NCH=1)
//  RST_VAL 0   reset value of every PO channel word (WIDTH bits)
// PORTS
//  TCK      in   1          clock (JTAG TCK); all state updates on rising edge
//  RST      in   1          reset, synchronous, active-high
//  DRCK_EN  in   1          DR clock enable from TAP
//  SEL      in   1          user instruction selected
//  CH       in   CHW        channel index, sampled only on a qualified CAPTURE
//  TDI      in   1          serial data in
//  CAPTURE  in   1          Capture-DR state
//  SHIFT    in   1          Shift-DR state
//  UPDATE   in   1          Update-DR state
//  CLR_ERR  in   1          clears LEN_ERR (qualified by ce)
//  PI       in   NCH*WIDTH  parallel status, channel k = PI[k*WIDTH +: WIDTH]
//  TDO      out  1          serial out; = q[0] while ce & SHIFT, else 0 (combinational)
//  PO       out  NCH*WIDTH  shadow control words, channel k = PO[k*WIDTH +: WIDTH]
//  UPD_STB  out  NCH        one-cycle pulse on the channel just committed
//  LEN_ERR  out  1          sticky: bad shift length or UPDATE without a CAPTURE
//  BUSY     out  1          1 when state != IDLE
// BEHAVIOUR
//  ce = SEL & DRCK_EN. Every CAPTURE/SHIFT/UPDATE/CLR_ERR action requires ce=1.
//  Reset (RST=1 at an edge): q=0, cnt=0, ch_l=0, state=IDLE, PO=all RST_VAL, UPD_STB=0,
//   LEN_ERR=0. RST overrides every other input, including mid-shift; the pending word is lost.
//  Priority within one edge: CAPTURE > UPDATE > SHIFT.
//  Internal: q[WIDTH-1:0], ch_l[CHW-1:0], cnt saturating at WIDTH+1 (width clog2(WIDTH+2)).
//  FSM states IDLE, ARMED, SHIFTING:
//   any, CAPTURE: q<=PI[CH], ch_l<=CH, cnt<=0, ->ARMED. A CH value >= NCH captures 0 and
//    sets LEN_ERR, ->IDLE.
//   ARMED/SHIFTING, SHIFT: q<={TDI,q[WIDTH-1:1]}, cnt<=min(cnt+1,WIDTH+1), ->SHIFTING.
//   IDLE, SHIFT: q still shifts (bypass-like), cnt unchanged, stays IDLE.
//   ARMED/SHIFTING, UPDATE: if cnt==WIDTH, PO[ch_l]<=q and UPD_STB[ch_l]<=1 next cycle.
//    Otherwise LEN_ERR<=1 and PO is unchanged. Either way ->IDLE.
//   IDLE, UPDATE: no PO change, LEN_ERR<=1.
//  UPD_STB is registered: high exactly one TCK after the UPDATE edge, then 0. Never >1 bit set.
//  CLR_ERR with ce: LEN_ERR<=0. If the same edge sets LEN_ERR, the set wins.
//  Zero-length shift (CAPTURE then UPDATE) counts as an error. So does cnt==WIDTH+1 (overrun).
//  PO channels that are not addressed hold their value. PI is sampled only at CAPTURE.
//  Latency: capture -> first TDO bit valid the cycle after CAPTURE; TDO bit i is PI[ch][i].
// TESTING (WIDTH=8, NCH=4)
//  1. RST=1 for 1 edge mid-shift -> PO=all 0x00, LEN_ERR=0, BUSY=0, UPD_STB=0, TDO=0.
//  2. CH=2, PI ch2=0xA5, CAPTURE, 8 SHIFT with TDI=0x3C LSB first -> TDO bits 1,0,1,0,0,1,0,1;
//     UPDATE -> PO ch2=0x3C, UPD_STB=4'b0100 for 1 cycle, others unchanged, LEN_ERR=0.
//  3. CAPTURE ch1, 7 SHIFT, UPDATE -> PO ch1 unchanged, LEN_ERR=1; CLR_ERR -> LEN_ERR=0.
//  4. CAPTURE ch0, 12 SHIFT, UPDATE -> overrun: LEN_ERR=1, no UPD_STB, PO unchanged.
//  5. SEL=0 or DRCK_EN=0 during full CAPTURE/8xSHIFT/UPDATE sequence -> no state change, TDO=0.
//  6. UPDATE from IDLE, then CAPTURE+UPDATE on same edge -> LEN_ERR=1; capture taken, BUSY=1.

Source files
------------

// File: rtl/user_dr_bank.sv
// Multi-channel JTAG user data register: captures a channel's status into a shared shift chain
// and commits the shifted-in word to that channel's shadow output on a full-length UPDATE.
module user_dr_bank #(
  parameter int WIDTH = 16,
  parameter int NCH = 4,
  parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                 TCK,
  input  logic                 RST,
  input  logic                 DRCK_EN,
  input  logic                 SEL,
  input  logic [CHW-1:0]       CH,
  input  logic                 TDI,
  input  logic                 CAPTURE,
  input  logic                 SHIFT,
  input  logic                 UPDATE,
  input  logic                 CLR_ERR,
  input  logic [NCH*WIDTH-1:0] PI,
  output logic                 TDO,
  output logic [NCH*WIDTH-1:0] PO,
  output logic [NCH-1:0]       UPD_STB,
  output logic                 LEN_ERR,
  output logic                 BUSY
);

  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH + 1);
  localparam logic [CHW:0] NCH_LIM = (CHW + 1)'(NCH);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFTING} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CHW-1:0]   ch_reg, ch_next;
  logic [NCH-1:0]   stb_reg, stb_next;
  logic             err_reg, err_next;
  logic             err_set;
  logic             po_we;
  logic             ce;
  logic             ch_ok;
  logic [WIDTH-1:0] pi_ch  [NCH];
  logic [WIDTH-1:0] po_reg [NCH];

  assign ce = SEL & DRCK_EN;
  assign ch_ok = ({1'b0, CH} < NCH_LIM);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign pi_ch[gi] = PI[gi*WIDTH +: WIDTH];
      assign PO[gi*WIDTH +: WIDTH] = po_reg[gi];

      always_ff @(posedge TCK) begin
        if (RST) begin
          po_reg[gi] <= RST_VAL;
        end else if (po_we && (ch_reg == CHW'(gi))) begin
          po_reg[gi] <= q_reg;
        end
      end
    end
  endgenerate

  always_ff @(posedge TCK) begin
    if (RST) begin
      state_reg <= IDLE;
      q_reg     <= '0;
      cnt_reg   <= '0;
      ch_reg    <= '0;
      stb_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      cnt_reg   <= cnt_next;
      ch_reg    <= ch_next;
      stb_reg   <= stb_next;
      err_reg   <= err_next;
    end
  end

  // CAPTURE outranks UPDATE, which outranks SHIFT; nothing moves without ce.
  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    cnt_next   = cnt_reg;
    ch_next    = ch_reg;
    stb_next   = '0;
    err_set    = 1'b0;
    po_we      = 1'b0;
    if (ce) begin
      if (CAPTURE) begin
        cnt_next = '0;
        if (ch_ok) begin
          q_next     = pi_ch[CH];
          ch_next    = CH;
          state_next = ARMED;
        end else begin
          q_next     = '0;
          ch_next    = '0;
          err_set    = 1'b1;
          state_next = IDLE;
        end
      end else if (UPDATE) begin
        state_next = IDLE;
        if ((state_reg != IDLE) && (cnt_reg == CNT_FULL)) begin
          po_we            = 1'b1;
          stb_next[ch_reg] = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end else if (SHIFT) begin
        q_next = {TDI, q_reg[WIDTH-1:1]};
        if (state_reg != IDLE) begin
          cnt_next   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
          state_next = SHIFTING;
        end
      end
    end
    // A new error on the same edge beats a clear request.
    if (err_set) begin
      err_next = 1'b1;
    end else if (ce && CLR_ERR) begin
      err_next = 1'b0;
    end else begin
      err_next = err_reg;
    end
  end

  assign TDO = (ce && SHIFT) ? q_reg[0] : 1'b0;
  assign UPD_STB = stb_reg;
  assign LEN_ERR = err_reg;
  assign BUSY = (state_reg != IDLE);

endmodule

// File: tb/tb_user_dr_bank.sv
// Scoreboarded bench for user_dr_bank: a bit-queue reference model predicts TDO bits and
// committed words; a monitor branch checks them whenever the DUT shifts or strobes.
module tb_user_dr_bank;
  localparam int W = 8;
  localparam int N = 4;

  logic         TCK = 1'b0;
  logic         RST = 1'b0;
  logic         DRCK_EN = 1'b0;
  logic         SEL = 1'b0;
  logic [1:0]   CH = '0;
  logic         TDI = 1'b0;
  logic         CAPTURE = 1'b0;
  logic         SHIFT = 1'b0;
  logic         UPDATE = 1'b0;
  logic         CLR_ERR = 1'b0;
  logic [N*W-1:0] PI = '0;
  logic         TDO;
  logic [N*W-1:0] PO;
  logic [N-1:0] UPD_STB;
  logic         LEN_ERR;
  logic         BUSY;

  user_dr_bank #(.WIDTH(W), .NCH(N), .CHW(2), .RST_VAL(8'h00)) dut (
    .TCK(TCK), .RST(RST), .DRCK_EN(DRCK_EN), .SEL(SEL), .CH(CH), .TDI(TDI),
    .CAPTURE(CAPTURE), .SHIFT(SHIFT), .UPDATE(UPDATE), .CLR_ERR(CLR_ERR), .PI(PI),
    .TDO(TDO), .PO(PO), .UPD_STB(UPD_STB), .LEN_ERR(LEN_ERR), .BUSY(BUSY)
  );

  always #5 TCK = ~TCK;

  // Reference model: the shift chain is a FIFO of bits, the shift length an unbounded count.
  bit         m_q[$];
  logic [7:0] m_po[N];
  bit         m_err;
  bit         m_active;
  int         m_nsh;
  int         m_ch;

  bit         tdo_q[$];
  int         upd_ch_q[$];
  logic [7:0] upd_w_q[$];

  int  n_tests = 0;
  int  n_fail = 0;
  bit  mon_en = 0;
  bit  done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < W; i++) m_q.push_back(1'b0);
    for (int k = 0; k < N; k++) m_po[k] = 8'h00;
    m_err = 0;
    m_active = 0;
    m_nsh = 0;
    m_ch = 0;
  endtask

  // One TCK cycle: predict, then drive and let the edge happen.
  task automatic cyc(input bit sel, input bit drck, input bit cap, input bit sh,
                     input bit upd, input bit clr, input logic [1:0] ch, input bit tdi);
    bit ce;
    bit set;
    bit b;
    logic [7:0] w;
    logic [7:0] cw;
    ce = sel & drck;
    set = 0;
    if (ce && sh) tdo_q.push_back(m_q[0]);
    if (ce && cap) begin
      cw = PI[int'(ch)*W +: W];
      m_q.delete();
      for (int i = 0; i < W; i++) m_q.push_back(cw[i]);
      m_active = 1;
      m_nsh = 0;
      m_ch = int'(ch);
    end else if (ce && upd) begin
      if (m_active && m_nsh == W) begin
        for (int i = 0; i < W; i++) w[i] = m_q[i];
        m_po[m_ch] = w;
        upd_ch_q.push_back(m_ch);
        upd_w_q.push_back(w);
      end else begin
        set = 1;
      end
      m_active = 0;
    end else if (ce && sh) begin
      b = m_q.pop_front();
      m_q.push_back(tdi);
      if (m_active) m_nsh++;
    end
    if (set) m_err = 1;
    else if (ce && clr) m_err = 0;
    SEL = sel; DRCK_EN = drck; CAPTURE = cap; SHIFT = sh; UPDATE = upd;
    CLR_ERR = clr; CH = ch; TDI = tdi;
    @(posedge TCK);
    #1;
    SEL = 0; DRCK_EN = 0; CAPTURE = 0; SHIFT = 0; UPDATE = 0; CLR_ERR = 0; TDI = 0;
  endtask

  task automatic do_reset();
    SEL = 0; DRCK_EN = 0; CAPTURE = 0; SHIFT = 0; UPDATE = 0; CLR_ERR = 0;
    RST = 1;
    model_reset();
    @(posedge TCK);
    #1;
    RST = 0;
    chk("stb_after_rst", 32'(UPD_STB), 32'h0);
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < N; k++) chk({tag, "_po"}, 32'(PO[k*W +: W]), 32'(m_po[k]));
    chk({tag, "_len_err"}, 32'(LEN_ERR), 32'(m_err));
    chk({tag, "_busy"}, 32'(BUSY), 32'(m_active));
  endtask

  // capture, nsh shifts (each optionally losing ce), update
  task automatic seq(input logic [1:0] ch, input logic [7:0] piw, input logic [7:0] tdiw,
                     input int nsh, input int drop_pct);
    bit s;
    PI[int'(ch)*W +: W] = piw;
    cyc(1, 1, 1, 0, 0, 0, ch, 0);
    for (int i = 0; i < nsh; i++) begin
      s = ($urandom_range(99) >= drop_pct);
      cyc(s, 1, 0, 1, 0, 0, ch, tdiw[i % W]);
    end
    cyc(1, 1, 0, 0, 1, 0, ch, 0);
  endtask

  initial begin
    fork
      begin : stimulus
        model_reset();
        @(posedge TCK);
        #1;
        do_reset();
        mon_en = 1;
        check_state("reset");

        // known-good write to channel 2
        seq(2'd2, 8'hA5, 8'h3C, 8, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check_state("good_ch2");
        chk("po_ch2_literal", 32'(PO[2*W +: W]), 32'h3C);

        // short shift
        seq(2'd1, 8'h5A, 8'hFF, 7, 0);
        check_state("short");
        cyc(1, 1, 0, 0, 0, 1, 0, 0);
        check_state("clr_err");

        // overrun
        seq(2'd0, 8'h11, 8'h77, 12, 0);
        check_state("overrun");
        cyc(1, 1, 0, 0, 0, 1, 0, 0);

        // ce missing: SEL low, then DRCK_EN low
        PI[3*W +: W] = 8'hC3;
        cyc(0, 1, 1, 0, 0, 0, 2'd3, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 1, 0, 0, 2'd3, 1);
        cyc(0, 1, 0, 0, 1, 0, 2'd3, 0);
        check_state("sel_off");
        cyc(1, 0, 1, 0, 0, 0, 2'd3, 0);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1, 0, 0, 2'd3, 1);
        cyc(1, 0, 0, 0, 1, 0, 2'd3, 0);
        check_state("drck_off");

        // update from idle, then capture+update on one edge
        cyc(1, 1, 0, 0, 1, 0, 0, 0);
        check_state("upd_idle");
        cyc(1, 1, 0, 0, 0, 1, 0, 0);
        cyc(1, 1, 1, 0, 1, 0, 2'd1, 0);
        check_state("cap_upd");
        chk("cap_upd_busy", 32'(BUSY), 32'h1);

        // reset in the middle of a shift
        seq(2'd3, 8'h96, 8'h69, 8, 0);
        PI[1*W +: W] = 8'hE7;
        cyc(1, 1, 1, 0, 0, 0, 2'd1, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1, 0, 0, 2'd1, 1);
        do_reset();
        check_state("mid_rst");

        // randomized sequences
        for (int t = 0; t < 80; t++) begin
          int nsh;
          int drop;
          nsh = ($urandom_range(3) == 0) ? int'($urandom_range(12)) : W;
          drop = ($urandom_range(3) == 0) ? 12 : 0;
          seq(2'($urandom_range(3)), 8'($urandom), 8'($urandom), nsh, drop);
          for (int j = 0; j < int'($urandom_range(2)); j++)
            cyc(1, 1, 0, $urandom_range(1), 0, $urandom_range(3) == 0, 0, $urandom_range(1));
          if ($urandom_range(19) == 0) do_reset();
          check_state("rand");
        end

        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        done = 1;
        @(negedge TCK);
      end
      begin : monitor
        while (!done) begin
          @(negedge TCK);
          if (mon_en) begin
            if (SEL && DRCK_EN && SHIFT) begin
              if (tdo_q.size() == 0) chk("tdo_unexpected_shift", 32'h1, 32'h0);
              else chk("tdo_bit", 32'(TDO), 32'(tdo_q.pop_front()));
            end else begin
              chk("tdo_quiet", 32'(TDO), 32'h0);
            end
            if (UPD_STB !== '0) begin
              if (upd_ch_q.size() == 0) begin
                chk("upd_stb_unexpected", 32'(UPD_STB), 32'h0);
              end else begin
                int c;
                logic [7:0] w;
                c = upd_ch_q.pop_front();
                w = upd_w_q.pop_front();
                chk("upd_stb", 32'(UPD_STB), 32'(1 << c));
                chk("upd_po", 32'(PO[c*W +: W]), 32'(w));
              end
            end
          end
        end
      end
    join
    chk("upd_drain", 32'(upd_ch_q.size()), 32'h0);
    chk("tdo_drain", 32'(tdo_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
